// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch/data memory arbiter: port tags and default geometry.
// Pure declarations; no timing or flow-control behaviour lives here.
package mem_arb_pkg;

    localparam int AW_DEF   = 12;
    localparam int DW_DEF   = 32;
    localparam int LAT_DEF  = 1;
    localparam int DMAX_DEF = 4;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arb_if.sv
// Request/grant/response bundle between the two requesters, the arbiter and the RAM.
// slave = arbiter view; master = environment view (requesters plus RAM read data).
interface mem_arb_if #(
    parameter int AW = 12,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_we, m_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, m_addr, m_we, m_wdata
    );

endinterface

// File: rtl/mem_arb_tagpipe.sv
// LAT-deep valid+port-tag shift register tracking reads in flight to the RAM.
// Latency exactly LAT cycles; no backpressure, one entry accepted per cycle.
module mem_arb_tagpipe
    import mem_arb_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  vld_i,
    input  port_e tag_i,
    output logic  vld_o,
    output port_e tag_o
);

    logic [LAT-1:0] vld_q;
    port_e          tag_q [LAT];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) tag_q[k] <= PORT_I;
        end else begin
            vld_q[0] <= vld_i;
            tag_q[0] <= tag_i;
            for (int k = 1; k < LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    assign vld_o = vld_q[LAT-1];
    assign tag_o = tag_q[LAT-1];

endmodule

// File: rtl/mem_arb.sv
// Fetch/data arbiter for one single-port sync RAM; data wins unless DMAX streak reached.
// Grant is combinational, read data returns LAT cycles later; MEM_ARB_PERF_EN adds stall counters.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF,
    parameter int LAT  = LAT_DEF,
    parameter int DMAX = DMAX_DEF
) (
    input  logic        clock,
    input  logic        reset,
    mem_arb_if.slave    bus
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_istall,
    output logic [31:0] perf_dstall
`endif
);

    localparam int             SW     = $clog2(DMAX + 1);
    localparam logic [SW-1:0]  DMAX_S = SW'(DMAX);

    logic [SW-1:0] streak_q, streak_d;
    logic          i_gnt_w, d_gnt_w;
    logic [AW-1:0] m_addr_w;
    logic          m_we_w;
    logic [DW-1:0] m_wdata_w;
    logic          pipe_vld;
    port_e         pipe_tag;

    // Grants are gated by reset so nothing reaches the RAM while it is held.
    always_comb begin
        i_gnt_w   = 1'b0;
        d_gnt_w   = 1'b0;
        m_addr_w  = '0;
        m_we_w    = 1'b0;
        m_wdata_w = '0;
        if (reset) begin
            if (bus.d_req && !(bus.i_req && streak_q == DMAX_S)) d_gnt_w = 1'b1;
            else if (bus.i_req)                                  i_gnt_w = 1'b1;
        end
        if (i_gnt_w) begin
            m_addr_w = bus.i_addr;
        end else if (d_gnt_w) begin
            m_addr_w  = bus.d_addr;
            m_we_w    = bus.d_we;
            m_wdata_w = bus.d_wdata;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!bus.i_req || i_gnt_w)                streak_d = '0;
        else if (d_gnt_w && streak_q != DMAX_S)   streak_d = streak_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) streak_q <= '0;
        else        streak_q <= streak_d;
    end

    mem_arb_tagpipe #(.LAT(LAT)) u_tagpipe (
        .clock (clock),
        .reset (reset),
        .vld_i (i_gnt_w | (d_gnt_w & ~bus.d_we)),
        .tag_i (d_gnt_w ? PORT_D : PORT_I),
        .vld_o (pipe_vld),
        .tag_o (pipe_tag)
    );

    assign bus.i_gnt    = i_gnt_w;
    assign bus.d_gnt    = d_gnt_w;
    assign bus.m_addr   = m_addr_w;
    assign bus.m_we     = m_we_w;
    assign bus.m_wdata  = m_wdata_w;
    assign bus.i_rvalid = pipe_vld && (pipe_tag == PORT_I);
    assign bus.d_rvalid = pipe_vld && (pipe_tag == PORT_D);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] istall_q, dstall_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            istall_q <= '0;
            dstall_q <= '0;
        end else begin
            if (bus.i_req && !i_gnt_w && istall_q != '1) istall_q <= istall_q + 1'b1;
            if (bus.d_req && !d_gnt_w && dstall_q != '1) dstall_q <= dstall_q + 1'b1;
        end
    end

    assign perf_istall = istall_q;
    assign perf_dstall = dstall_q;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: LAT=1 instance (a) and LAT=3 instance (b), DMAX=4 on both.
module tb_mem_arb;
    import mem_arb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    mem_arb_if #(.AW(12), .DW(32)) a ();
    mem_arb_if #(.AW(12), .DW(32)) b ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] pi1, pd1, pi3, pd3;
`endif

    mem_arb #(.AW(12), .DW(32), .LAT(1), .DMAX(4)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (a.slave)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_istall (pi1),
        .perf_dstall (pd1)
`endif
    );

    mem_arb #(.AW(12), .DW(32), .LAT(3), .DMAX(4)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (b.slave)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_istall (pi3),
        .perf_dstall (pd3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        a.i_req = 1'b0; a.i_addr = '0; a.d_req = 1'b0; a.d_we = 1'b0; a.d_addr = '0; a.d_wdata = '0;
        b.i_req = 1'b0; b.i_addr = '0; b.d_req = 1'b0; b.d_we = 1'b0; b.d_addr = '0; b.d_wdata = '0;
    endtask

    initial begin
        logic exp_d, prev_d, ev, od;
        idle_all();
        a.m_rdata = '0;
        b.m_rdata = '0;

        // Requests during reset must not be granted
        #1;
        a.i_req = 1'b1; a.d_req = 1'b1; a.d_we = 1'b1;
        #1;
        chk("rst_i_gnt",    a.i_gnt,    0);
        chk("rst_d_gnt",    a.d_gnt,    0);
        chk("rst_m_we",     a.m_we,     0);
        chk("rst_i_rvalid", a.i_rvalid, 0);
        chk("rst_d_rvalid", a.d_rvalid, 0);
        idle_all();
        @(negedge clock); reset = 1'b1;

        // Lone fetch read, LAT=1
        @(negedge clock);
        a.i_req = 1'b1; a.i_addr = 12'h010;
        #1;
        chk("f_i_gnt",  a.i_gnt,  1);
        chk("f_d_gnt",  a.d_gnt,  0);
        chk("f_m_addr", a.m_addr, 32'h010);
        chk("f_m_we",   a.m_we,   0);
        @(negedge clock);
        a.i_req = 1'b0; a.m_rdata = 32'hCAFE0010;
        #1;
        chk("f_i_rvalid", a.i_rvalid, 1);
        chk("f_i_rdata",  a.i_rdata,  32'hCAFE0010);
        chk("f_d_rdata",  a.d_rdata,  32'hCAFE0010);
        chk("f_d_rvalid", a.d_rvalid, 0);
        chk("idle_m_addr", a.m_addr, 0);
        @(negedge clock); #1;
        chk("f_i_rvalid_1shot", a.i_rvalid, 0);

        // Data write: no rvalid follows
        @(negedge clock);
        a.d_req = 1'b1; a.d_we = 1'b1; a.d_addr = 12'h3FF; a.d_wdata = 32'hDEADBEEF;
        #1;
        chk("w_d_gnt",   a.d_gnt,   1);
        chk("w_m_we",    a.m_we,    1);
        chk("w_m_wdata", a.m_wdata, 32'hDEADBEEF);
        chk("w_m_addr",  a.m_addr,  32'h3FF);
        @(negedge clock);
        a.d_req = 1'b0; a.d_we = 1'b0; a.d_addr = '0; a.d_wdata = '0;
        #1;
        chk("w_no_rvalid", a.d_rvalid, 0);
        chk("w_m_we_off",  a.m_we,     0);
        @(negedge clock); #1;
        chk("w_no_rvalid2", a.d_rvalid, 0);

        // Contention: d,d,d,d,i repeating; d reads return one cycle later
        prev_d = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            a.i_req = 1'b1; a.i_addr = 12'h020;
            a.d_req = 1'b1; a.d_we = 1'b0; a.d_addr = 12'h030;
            #1;
            exp_d = (c % 5) != 4;
            chk($sformatf("arb_d_gnt_c%0d", c), a.d_gnt, exp_d);
            chk($sformatf("arb_i_gnt_c%0d", c), a.i_gnt, !exp_d);
            chk($sformatf("arb_m_addr_c%0d", c), a.m_addr, exp_d ? 32'h030 : 32'h020);
            if (c > 0) chk($sformatf("arb_d_rvalid_c%0d", c), a.d_rvalid, prev_d);
            prev_d = exp_d;
        end
        @(negedge clock);
        idle_all();
        #1;
`ifdef MEM_ARB_PERF_EN
        chk("perf_istall", pi1, 8);
        chk("perf_dstall", pd1, 2);
`endif

        // Build a streak of 2 and launch reads on both instances, then reset
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            a.i_req = 1'b1; a.d_req = 1'b1; a.d_we = 1'b0; a.d_addr = 12'h044;
            b.i_req = (c == 1); b.i_addr = 12'h055;
            #1;
            chk($sformatf("pre_rst_d_gnt_c%0d", c), a.d_gnt, 1);
        end
        @(negedge clock);
        idle_all();
        reset = 1'b0;
        #1;
        chk("rst_clr_d_rvalid", a.d_rvalid, 0);
        @(negedge clock); reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock); #1;
            chk($sformatf("post_rst_a_rvalid_c%0d", c), a.d_rvalid | a.i_rvalid, 0);
            chk($sformatf("post_rst_b_rvalid_c%0d", c), b.i_rvalid | b.d_rvalid, 0);
        end
        // Streak must restart from 0: four d grants before i
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            a.i_req = 1'b1; a.d_req = 1'b1; a.d_we = 1'b0;
            #1;
            chk($sformatf("streak0_i_gnt_c%0d", c), a.i_gnt, c == 4);
        end
        @(negedge clock);
        idle_all();
        #1;
`ifdef MEM_ARB_PERF_EN
        chk("perf_istall_after_rst", pi1, 4);
        chk("perf_dstall_after_rst", pd1, 1);
`endif

        // LAT=3 alternating i/d reads: each rvalid exactly 3 cycles after its grant
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            b.i_req = (c < 8) && (c % 2 == 0); b.i_addr = 12'(12'h100 + c);
            b.d_req = (c < 8) && (c % 2 == 1); b.d_we = 1'b0; b.d_addr = 12'(12'h200 + c);
            b.m_rdata = 32'hB0000000 + 32'(c);
            #1;
            if (c < 8) begin
                chk($sformatf("l3_i_gnt_c%0d", c), b.i_gnt, c % 2 == 0);
                chk($sformatf("l3_d_gnt_c%0d", c), b.d_gnt, c % 2 == 1);
            end
            ev = (c >= 3) && (c < 11) && ((c - 3) % 2 == 0);
            od = (c >= 3) && (c < 11) && ((c - 3) % 2 == 1);
            chk($sformatf("l3_i_rvalid_c%0d", c), b.i_rvalid, ev);
            chk($sformatf("l3_d_rvalid_c%0d", c), b.d_rvalid, od);
            if (ev) chk($sformatf("l3_i_rdata_c%0d", c), b.i_rdata, 32'hB0000000 + 32'(c));
            if (od) chk($sformatf("l3_d_rdata_c%0d", c), b.d_rdata, 32'hB0000000 + 32'(c));
        end
        idle_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameters, one per line:
- AW, 12, address width.
- DW, 32, data width.
- LAT, 1, memory read latency in cycles, legal range 1..4.
- DMAX, 4, maximum number of consecutive contested data grants before a fetch is forced.

REQ-002 SHALL have the following ports, one per line (clock and reset first):
- clock  in  1  single clock; all state is updated on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  fetch accepted this cycle.
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  DW  fetch data.
- d_req  in  1  data request.
- d_we  in  1  data write (1) or read (0).
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data access accepted this cycle.
- d_rvalid  out  1  load data valid.
- d_rdata  out  DW  load data.
- m_addr  out  AW  address to the single-port synchronous RAM.
- m_we  out  1  RAM write enable.
- m_wdata  out  DW  RAM write data.
- m_rdata  in  DW  RAM read data, valid LAT cycles after issue.

Function
REQ-003 SHALL grant at most one port per cycle; i_gnt and d_gnt are combinational from requests and state, and are never both 1.
REQ-004 SHALL grant the sole requester when only one of i_req/d_req is 1; grant nothing and drive m_addr=0, m_we=0, m_wdata=0 when neither requests.
REQ-005 SHALL, when both request, grant d unless the streak counter equals DMAX, in which case i is granted.
REQ-006 SHALL increment the streak counter on each d grant made while i_req=1, and clear it on any i grant or any cycle with i_req=0; it saturates at DMAX.
REQ-007 SHALL drive m_addr/m_we/m_wdata combinationally from the granted port; m_we=1 only for a granted d access with d_we=1.
REQ-008 SHALL assert i_rvalid (or d_rvalid) exactly LAT cycles after the grant of a read, for one cycle, with i_rdata/d_rdata = m_rdata in that cycle.
REQ-009 SHALL produce no rvalid for a granted write.
REQ-010 SHALL pass m_rdata to both i_rdata and d_rdata unconditionally; only rvalid qualifies the data.
REQ-011 SHALL accept a new grant every cycle regardless of reads in flight (fully pipelined, up to LAT outstanding reads).
REQ-012 SHALL let a requester drop req without a grant, with no side effect; requesters hold addr/we/wdata stable until granted.

Reset
REQ-013 SHALL, while reset=0, clear the streak counter and the in-flight tag pipeline, and force i_gnt, d_gnt, i_rvalid, d_rvalid and m_we to 0.
REQ-014 SHALL discard reads in flight at reset assertion; no rvalid may appear for them after reset releases.

Configuration
REQ-015 SHALL, with MEM_ARB_PERF_EN defined, add outputs perf_istall and perf_dstall (32 bits each); each counts cycles in which that port requests without a grant, saturates at all-ones, and clears on reset.
REQ-016 SHALL, without MEM_ARB_PERF_EN, omit those ports and counters; all other behaviour is identical.

Structure
REQ-017 SHALL place the port-tag constants (PORT_I=0, PORT_D=1) and the default AW/DW/LAT/DMAX values in package mem_arb_pkg.
REQ-018 SHALL implement the LAT-deep valid+tag shift register as sub-module mem_arb_tagpipe.

Verification (LAT=1, DMAX=4 unless stated)
REQ-019 SHALL cover: i_req=1, i_addr=0x010 alone -> i_gnt=1, m_addr=0x010; next cycle i_rvalid=1, i_rdata=m_rdata.
REQ-020 SHALL cover: both request continuously, d_we=0 -> d granted 4 cycles, i granted on the 5th, pattern repeats.
REQ-021 SHALL cover: d_req=1, d_we=1, d_addr=0x3FF, d_wdata=0xDEADBEEF -> d_gnt=1, m_we=1, m_wdata=0xDEADBEEF; no d_rvalid follows.
REQ-022 SHALL cover: LAT=3, alternating i/d reads every cycle -> rvalids return in issue order, each exactly 3 cycles after its grant.
REQ-023 SHALL cover: reset asserted the cycle after a read grant -> no rvalid after release; streak counter is 0.
REQ-024 SHALL cover: with MEM_ARB_PERF_EN, both ports request for 10 cycles -> perf_istall=8, perf_dstall=2.
